rdm_fsm_multi_user: RTL and testbench

Multi-user rate-dematching control FSM for the receive path. It sequences up to USER_NUM users. For each user it fetches the configuration (E, Ncb, k0), optionally clears the user's circular soft-buffer region, then streams E LLR words into the buffer at addresses (k0+i) mod Ncb. After the first wrap it flags combining for HARQ-style repetition accumulation. It sits between the LLR input FIFO and the soft-combining buffer RAM.

---
 rtl/rdm_fsm_multi_user.sv | 186 ++++++++++++++++++
 tb/tb_rdm_fsm_multi_user.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rdm_fsm_multi_user.sv
// Multi-user rate-dematching control FSM.
// Sequences users: fetches each user's (E, Ncb, k0), optionally zeroes the
// circular soft buffer, then streams E LLR words to addresses (k0+i) mod Ncb.
// Once the address wraps, writes are flagged for accumulation (combine).
module rdm_fsm_multi_user #(
  parameter int USER_NUM   = 8,
  parameter int USER_IDX_W = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_rx_fsm_rstn,
  input  logic                  i_start,
  input  logic [USER_IDX_W-1:0] i_user_num,
  input  logic                  i_clear_en,
  output logic                  o_cfg_req,
  output logic [USER_IDX_W-1:0] o_cfg_user_idx,
  input  logic                  i_cfg_vld,
  input  logic [LEN_WIDTH-1:0]  i_cfg_e,
  input  logic [ADDR_WIDTH:0]   i_cfg_ncb,
  input  logic [ADDR_WIDTH-1:0] i_cfg_k0,
  input  logic                  i_llr_vld,
  input  logic [DATA_WIDTH-1:0] i_llr_data,
  output logic                  o_llr_rdy,
  output logic                  o_buf_we,
  output logic [ADDR_WIDTH-1:0] o_buf_addr,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  output logic                  o_buf_combine,
  output logic                  o_user_done,
  output logic                  o_cfg_err,
  output logic                  o_busy,
  output logic                  o_all_done
);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    CFG_REQ  = 7'b0000010,
    CFG_WAIT = 7'b0000100,
    CLEAR    = 7'b0001000,
    RUN      = 7'b0010000,
    USER_END = 7'b0100000,
    DONE     = 7'b1000000
  } state_t;

  state_t                  state;
  logic [USER_IDX_W-1:0]   user_num_q;
  logic [USER_IDX_W-1:0]   user_idx;
  logic [LEN_WIDTH-1:0]    e_cnt;
  logic [ADDR_WIDTH:0]     ncb_q;
  logic [ADDR_WIDTH-1:0]   k0_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wrap;
  logic                    cfg_req_q, buf_we_q, buf_comb_q;
  logic                    user_done_q, cfg_err_q, all_done_q;
  logic [ADDR_WIDTH-1:0]   buf_addr_q;
  logic [DATA_WIDTH-1:0]   buf_data_q;

  logic                    xfer;
  logic                    at_end;
  logic                    cfg_bad;
  logic [USER_IDX_W:0]     idx_nxt;
  logic [ADDR_WIDTH:0]     ncb_m1;

  // Handshake and address-boundary decode from the registered context
  assign xfer    = i_llr_vld && o_llr_rdy;
  assign ncb_m1  = ncb_q - (ADDR_WIDTH+1)'(1);
  assign at_end  = ({1'b0, addr} == ncb_m1);
  assign cfg_bad = (i_cfg_ncb == '0) || ({1'b0, i_cfg_k0} >= i_cfg_ncb);
  assign idx_nxt = {1'b0, user_idx} + (USER_IDX_W+1)'(1);

  assign o_llr_rdy      = (state == RUN) && (e_cnt != '0);
  assign o_busy         = (state != IDLE);
  assign o_cfg_req      = cfg_req_q;
  assign o_cfg_user_idx = user_idx;
  assign o_buf_we       = buf_we_q;
  assign o_buf_addr     = buf_addr_q;
  assign o_buf_data     = buf_data_q;
  assign o_buf_combine  = buf_comb_q;
  assign o_user_done    = user_done_q;
  assign o_cfg_err      = cfg_err_q;
  assign o_all_done     = all_done_q;

  // Control FSM; the synchronous abort clears exactly what the async reset does,
  // so a write registered on the abort edge never reaches the buffer.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state <= IDLE;  user_num_q <= '0; user_idx <= '0; e_cnt <= '0;
      ncb_q <= '0;    k0_q <= '0;       addr <= '0;     wrap <= 1'b0;
      cfg_req_q <= 1'b0; buf_we_q <= 1'b0; buf_comb_q <= 1'b0;
      user_done_q <= 1'b0; cfg_err_q <= 1'b0; all_done_q <= 1'b0;
      buf_addr_q <= '0; buf_data_q <= '0;
    end else if (!i_rx_fsm_rstn) begin
      state <= IDLE;  user_num_q <= '0; user_idx <= '0; e_cnt <= '0;
      ncb_q <= '0;    k0_q <= '0;       addr <= '0;     wrap <= 1'b0;
      cfg_req_q <= 1'b0; buf_we_q <= 1'b0; buf_comb_q <= 1'b0;
      user_done_q <= 1'b0; cfg_err_q <= 1'b0; all_done_q <= 1'b0;
      buf_addr_q <= '0; buf_data_q <= '0;
    end else begin
      cfg_req_q   <= 1'b0;
      buf_we_q    <= 1'b0;
      user_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      all_done_q  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          if (i_user_num != '0) begin
            // clamp to the configured maximum user count
            user_num_q <= ({1'b0, i_user_num} > (USER_IDX_W+1)'(USER_NUM)) ?
                          USER_IDX_W'(USER_NUM) : i_user_num;
            user_idx   <= '0;
            cfg_req_q  <= 1'b1;
            state      <= CFG_REQ;
          end else begin
            all_done_q <= 1'b1;
            state      <= DONE;
          end
        end
        CFG_REQ: state <= CFG_WAIT;
        CFG_WAIT: if (i_cfg_vld) begin
          ncb_q <= i_cfg_ncb;
          k0_q  <= i_cfg_k0;
          e_cnt <= i_cfg_e;
          wrap  <= 1'b0;
          if (cfg_bad) begin
            cfg_err_q   <= 1'b1;
            user_done_q <= 1'b1;
            state       <= USER_END;
          end else if (i_cfg_e == '0) begin
            user_done_q <= 1'b1;
            state       <= USER_END;
          end else if (i_clear_en) begin
            addr  <= '0;
            state <= CLEAR;
          end else begin
            addr  <= i_cfg_k0;
            state <= RUN;
          end
        end
        CLEAR: begin
          buf_we_q   <= 1'b1;
          buf_addr_q <= addr;
          buf_data_q <= '0;
          buf_comb_q <= 1'b0;
          if (at_end) begin
            addr  <= k0_q;
            state <= RUN;
          end else begin
            addr  <= addr + ADDR_WIDTH'(1);
          end
        end
        RUN: if (xfer) begin
          buf_we_q   <= 1'b1;
          buf_addr_q <= addr;
          buf_data_q <= i_llr_data;
          buf_comb_q <= wrap;
          e_cnt      <= e_cnt - LEN_WIDTH'(1);
          if (at_end) begin
            addr <= '0;
            wrap <= 1'b1;
          end else begin
            addr <= addr + ADDR_WIDTH'(1);
          end
          if (e_cnt == LEN_WIDTH'(1)) begin
            user_done_q <= 1'b1;
            state       <= USER_END;
          end
        end
        USER_END: begin
          if (idx_nxt < {1'b0, user_num_q}) begin
            user_idx  <= idx_nxt[USER_IDX_W-1:0];
            cfg_req_q <= 1'b1;
            state     <= CFG_REQ;
          end else begin
            all_done_q <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdm_fsm_multi_user.sv
// Bench for rdm_fsm_multi_user: config responder, LLR source and a scoreboard
// of expected buffer writes built from the configuration handed to the DUT.
module tb_rdm_fsm_multi_user;
  localparam int AW = 11, DW = 48, LW = 16, IW = 4;

  logic          clk = 1'b0;
  logic          rstn, fsm_rstn, start, clear_en, cfg_vld, llr_vld;
  logic [IW-1:0] user_num;
  logic [LW-1:0] cfg_e;
  logic [AW:0]   cfg_ncb;
  logic [AW-1:0] cfg_k0;
  logic [DW-1:0] llr_data;
  logic          o_cfg_req, o_llr_rdy, o_buf_we, o_buf_combine;
  logic          o_user_done, o_cfg_err, o_busy, o_all_done;
  logic [IW-1:0] o_cfg_user_idx;
  logic [AW-1:0] o_buf_addr;
  logic [DW-1:0] o_buf_data;

  rdm_fsm_multi_user dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn),
    .i_start(start), .i_user_num(user_num), .i_clear_en(clear_en),
    .o_cfg_req(o_cfg_req), .o_cfg_user_idx(o_cfg_user_idx),
    .i_cfg_vld(cfg_vld), .i_cfg_e(cfg_e), .i_cfg_ncb(cfg_ncb), .i_cfg_k0(cfg_k0),
    .i_llr_vld(llr_vld), .i_llr_data(llr_data), .o_llr_rdy(o_llr_rdy),
    .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_data(o_buf_data),
    .o_buf_combine(o_buf_combine), .o_user_done(o_user_done),
    .o_cfg_err(o_cfg_err), .o_busy(o_busy), .o_all_done(o_all_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          comb;
    bit            clr;
    bit            last;
  } wr_t;

  wr_t sb[$];
  int  idx_q[$];
  int  n_chk = 0, n_fail = 0;
  int  n_ud, n_err, n_ad, n_wr;
  int  llr_seq = 0, push_seq = 0;
  bit  xfer_last = 1'b0, phase = 1'b0, tog_mode = 1'b0, abort_flag = 1'b0, clr_mode = 1'b0;
  int  rsp_cnt = -1, rsp_idx = 0;
  int  tab_e[16], tab_ncb[16], tab_k0[16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkd(input int s);
    return {16'hC3A5, 32'(s)};
  endfunction

  // expected writes for one user, built from the config the responder hands out
  task automatic push_user(input int u);
    int  e, n, k;
    wr_t w;
    e = tab_e[u]; n = tab_ncb[u]; k = tab_k0[u];
    if (n == 0 || k >= n || e == 0) return;
    if (clr_mode)
      for (int j = 0; j < n; j++) begin
        w.addr = AW'(j); w.data = '0; w.comb = 1'b0; w.clr = 1'b1; w.last = (j == n - 1);
        sb.push_back(w);
      end
    for (int i = 0; i < e; i++) begin
      w.addr = AW'((k + i) % n); w.data = mkd(push_seq); w.comb = ((k + i) >= n);
      w.clr = 1'b0; w.last = 1'b0;
      push_seq++;
      sb.push_back(w);
    end
  endtask

  // monitor, config responder and LLR source, all on the falling edge
  always @(negedge clk) begin
    wr_t w;
    if (o_buf_we) begin
      n_wr++;
      if (sb.size() == 0) chk("wr_unexp", o_buf_we, 0);
      else begin
        w = sb.pop_front();
        chk("wr_addr", o_buf_addr, w.addr);
        chk("wr_data", o_buf_data, w.data);
        chk("wr_comb", o_buf_combine, w.comb);
        if (w.clr && !w.last) chk("clr_rdy", o_llr_rdy, 0);
        if (!w.clr) chk("wr_lat", xfer_last, 1);
      end
    end else if (xfer_last && !abort_flag) chk("wr_miss", o_buf_we, 1);
    if (o_user_done) n_ud++;
    if (o_cfg_err) begin n_err++; chk("err_w_done", o_user_done, 1); end
    if (o_all_done) n_ad++;
    if (o_cfg_req) begin idx_q.push_back(int'(o_cfg_user_idx)); rsp_cnt = 2; rsp_idx = int'(o_cfg_user_idx); end
    cfg_vld = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        cfg_vld = 1'b1;
        cfg_e   = LW'(tab_e[rsp_idx]);
        cfg_ncb = (AW+1)'(tab_ncb[rsp_idx]);
        cfg_k0  = AW'(tab_k0[rsp_idx]);
        push_user(rsp_idx);
        rsp_cnt = -1;
      end
    end
    if (xfer_last) llr_seq++;
    phase     = ~phase;
    llr_vld   = tog_mode ? phase : 1'b1;
    llr_data  = mkd(llr_seq);
    xfer_last = llr_vld && o_llr_rdy && rstn;
  end

  task automatic set_u(input int u, input int e, input int n, input int k);
    tab_e[u] = e; tab_ncb[u] = n; tab_k0[u] = k;
  endtask

  task automatic clr_cnt();
    n_ud = 0; n_err = 0; n_ad = 0; n_wr = 0; idx_q.delete();
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    user_num = IW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (n_ad == 0 && c < budget) begin @(negedge clk); c++; end
    chk("done_timeout", (n_ad != 0), 1);
  endtask

  task automatic run_test(input string nm, input int nusers, input int exp_wr, input int exp_err);
    clr_cnt();
    pulse_start(nusers);
    wait_done(5000);
    repeat (3) @(negedge clk);
    chk({nm, "_nwr"}, n_wr, exp_wr);
    chk({nm, "_ud"}, n_ud, nusers);
    chk({nm, "_err"}, n_err, exp_err);
    chk({nm, "_ad"}, n_ad, 1);
    chk({nm, "_sb_left"}, sb.size(), 0);
    chk({nm, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int c;
    rstn = 1'b0; fsm_rstn = 1'b1; start = 1'b0; user_num = '0; clear_en = 1'b0;
    cfg_vld = 1'b0; cfg_e = '0; cfg_ncb = '0; cfg_k0 = '0; llr_vld = 1'b0; llr_data = '0;
    for (int i = 0; i < 16; i++) set_u(i, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ctl", {o_cfg_req, o_cfg_user_idx, o_llr_rdy, o_buf_we, o_buf_addr, o_buf_combine,
                    o_user_done, o_cfg_err, o_busy, o_all_done}, 0);
    chk("rst_data", o_buf_data, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // straight run, no wrap
    set_u(0, 10, 16, 3);        run_test("t1", 1, 10, 0);
    // multiple wraps, combine after first wrap
    set_u(0, 20, 8, 6);         run_test("t2", 1, 20, 0);
    // clear then data
    clr_mode = 1'b1; clear_en = 1'b1;
    set_u(0, 3, 5, 0);          run_test("t3", 1, 8, 0);
    clr_mode = 1'b0; clear_en = 1'b0;
    // three users, middle one illegal
    set_u(0, 5, 16, 0); set_u(1, 7, 8, 9); set_u(2, 4, 4, 2);
    run_test("t4", 3, 9, 1);
    chk("t4_nreq", idx_q.size(), 3);
    if (idx_q.size() == 3) begin
      chk("t4_idx0", idx_q[0], 0); chk("t4_idx1", idx_q[1], 1); chk("t4_idx2", idx_q[2], 2);
    end
    // gapped valid
    tog_mode = 1'b1;
    set_u(0, 4, 16, 0);         run_test("t5", 1, 4, 0);
    tog_mode = 1'b0;
    // zero users, E==0 user, full-size Ncb boundary
    run_test("t7", 0, 0, 0);
    set_u(0, 0, 16, 0);         run_test("t8", 1, 0, 0);
    set_u(0, 3, 2048, 2046);    run_test("t9", 1, 3, 0);

    // synchronous abort after the 2nd transfer
    set_u(0, 6, 16, 0);
    clr_cnt();
    c = llr_seq;
    abort_flag = 1'b1;
    pulse_start(1);
    begin
      int b = 0;
      while (llr_seq - c < 2 && b < 200) begin @(negedge clk); #1; b++; end
      chk("abort_timeout", (llr_seq - c >= 2), 1);
    end
    fsm_rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", o_busy, 0);
    #1 fsm_rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_wr_le2", (n_wr <= 2), 1);
    chk("abort_ud", n_ud, 0);
    chk("abort_ad", n_ad, 0);
    sb.delete(); push_seq = llr_seq; abort_flag = 1'b0;
    set_u(0, 10, 16, 3);        run_test("rerun", 1, 10, 0);

    // asynchronous reset in the middle of a clear
    clr_mode = 1'b1; clear_en = 1'b1;
    set_u(0, 3, 16, 0);
    clr_cnt();
    pulse_start(1);
    begin
      int b = 0;
      while (n_wr < 3 && b < 200) begin @(negedge clk); b++; end
      chk("arst_timeout", (n_wr >= 3), 1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("arst_ctl", {o_cfg_req, o_cfg_user_idx, o_llr_rdy, o_buf_we, o_buf_addr, o_buf_combine,
                     o_user_done, o_cfg_err, o_busy, o_all_done}, 0);
    chk("arst_data", o_buf_data, 0);
    @(negedge clk); #1 rstn = 1'b1;
    sb.delete(); push_seq = llr_seq;
    set_u(0, 3, 5, 0);          run_test("post_arst", 1, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
